key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_pkg.sv | 23 ++
 rtl/debounce_level.sv | 67 ++++++
 rtl/key_conditioner.sv | 166 ++++++++++++++++
 tb/tb_key_conditioner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared definitions for the key conditioner: key FSM state
//                type and the millisecond-to-clock-cycle helper.
//  Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,   // key released and stable
        ST_ARM_PRESS   = 2'd1,   // key seen low, qualifying the press
        ST_PRESSED     = 2'd2,   // press accepted, key held
        ST_ARM_RELEASE = 2'd3    // key seen high, qualifying the release
    } key_state_t;

    // Cycles of clk_hz in ms milliseconds (integer kHz assumed).
    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_level.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_level
//  Description : Two-flop synchronizer followed by a stable-count filter for
//                a level input. A level differing from the accepted one is
//                taken over after DB_CYC consecutive samples; any reversion
//                restarts the count. o_changed strobes together with each new
//                o_level except the very first acceptance after reset.
//  Ports       : clk, rst (async, active high)
//                i_raw     - asynchronous raw level
//                o_level   - debounced level (reset 0)
//                o_changed - one-cycle strobe on level change
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_level #(
    parameter int DB_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_changed
);

    localparam int c_CNT_W = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYC - 1);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;
    logic               r_changed;
    logic               r_primed;   // set once the first level has been loaded

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta    <= 1'b0;
            r_sync    <= 1'b0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_changed <= 1'b0;
            r_primed  <= 1'b0;
        end else begin
            r_meta    <= i_raw;
            r_sync    <= r_meta;
            r_changed <= 1'b0;
            if (r_sync != r_level) begin
                if (r_cnt == c_CNT_LAST) begin
                    r_level   <= r_sync;
                    r_cnt     <= '0;
                    r_primed  <= 1'b1;
                    // The first acceptance only initialises the level.
                    r_changed <= r_primed;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level   = r_level;
    assign o_changed = r_changed;

endmodule
`default_nettype wire

// File: rtl/key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : key_conditioner
//  Description : Conditions the start/stop key (active low) and the mode
//                switch. The key goes through a synchronizer and a four-state
//                debounce FSM that emits one strobe per accepted press. The
//                switch is debounced by a debounce_level instance.
//                Optional macro KEY_LONG_PRESS_EN adds a hold counter that
//                emits ClearPulse once per long press; without it ClearPulse
//                is tied low.
//  Ports       : CLK_50MHz        - sole clock
//                rst              - asynchronous active-high reset
//                StartStopKey     - raw key level, 0 = pressed
//                ModeSw           - raw mode switch level
//                StartStopPulse   - one-cycle strobe per accepted press
//                ClearPulse       - one-cycle strobe per long press
//                ModeSelClean     - debounced switch level
//                ModeChangedPulse - one-cycle strobe on ModeSelClean change
//  Revision    : 1.0  initial release
// ============================================================================
module key_conditioner
    import key_pkg::*;
#(
    parameter int CLK_HZ        = 50000000,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 2000
) (
    input  logic CLK_50MHz,
    input  logic rst,
    input  logic StartStopKey,
    input  logic ModeSw,
    output logic StartStopPulse,
    output logic ClearPulse,
    output logic ModeSelClean,
    output logic ModeChangedPulse
);

    localparam int c_DB_CYC = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int c_DB_W   = (c_DB_CYC > 1) ? $clog2(c_DB_CYC) : 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(c_DB_CYC - 1);

    // ------------------------------------------------------------------
    // Key synchronizer, resets to the released level
    // ------------------------------------------------------------------
    logic r_key_meta;
    logic r_key_sync;

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            r_key_meta <= 1'b1;
            r_key_sync <= 1'b1;
        end else begin
            r_key_meta <= StartStopKey;
            r_key_sync <= r_key_meta;
        end
    end

    // ------------------------------------------------------------------
    // Key FSM. The strobe is issued only on ARM_PRESS -> PRESSED, so a
    // release bounce returning to PRESSED stays silent.
    // ------------------------------------------------------------------
    key_state_t        r_state;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_start_pulse;

    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_db_cnt      <= '0;
            r_start_pulse <= 1'b0;
        end else begin
            r_start_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_key_sync) begin
                        r_state  <= ST_ARM_PRESS;
                        r_db_cnt <= '0;
                    end
                end
                ST_ARM_PRESS: begin
                    if (r_key_sync) begin
                        r_state <= ST_IDLE;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state       <= ST_PRESSED;
                        r_start_pulse <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (r_key_sync) begin
                        r_state  <= ST_ARM_RELEASE;
                        r_db_cnt <= '0;
                    end
                end
                ST_ARM_RELEASE: begin
                    if (!r_key_sync) begin
                        r_state <= ST_PRESSED;
                    end else if (r_db_cnt == c_DB_LAST) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign StartStopPulse = r_start_pulse;

    // ------------------------------------------------------------------
    // Long-press detection
    // ------------------------------------------------------------------
`ifdef KEY_LONG_PRESS_EN
    localparam int c_LP_CYC = ms_to_cycles(CLK_HZ, LONG_PRESS_MS);
    localparam int c_LP_W   = $clog2(c_LP_CYC + 1);
    localparam logic [c_LP_W-1:0] c_LP_FULL = c_LP_W'(c_LP_CYC);
    localparam logic [c_LP_W-1:0] c_LP_LAST = c_LP_W'(c_LP_CYC - 1);

    logic [c_LP_W-1:0] r_hold_cnt;
    logic              r_clear_pulse;

    // Counts while the press is accepted (bounces in ARM_RELEASE keep the
    // count) and saturates, so the strobe fires only once per press.
    always_ff @(posedge CLK_50MHz or posedge rst) begin
        if (rst) begin
            r_hold_cnt    <= '0;
            r_clear_pulse <= 1'b0;
        end else begin
            r_clear_pulse <= 1'b0;
            if (r_state == ST_PRESSED || r_state == ST_ARM_RELEASE) begin
                if (r_hold_cnt != c_LP_FULL) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (r_hold_cnt == c_LP_LAST) begin
                        r_clear_pulse <= 1'b1;
                    end
                end
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign ClearPulse = r_clear_pulse;
`else
    assign ClearPulse = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Mode switch path
    // ------------------------------------------------------------------
    debounce_level #(
        .DB_CYC (c_DB_CYC)
    ) u_mode_db (
        .clk       (CLK_50MHz),
        .rst       (rst),
        .i_raw     (ModeSw),
        .o_level   (ModeSelClean),
        .o_changed (ModeChangedPulse)
    );

endmodule
`default_nettype wire

// File: tb/tb_key_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_conditioner
//  Description : Self-checking bench for key_conditioner with
//                CLK_HZ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=20.
//                A reference model tracks, per input, how long the
//                synchronized level has disagreed with the accepted level.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_conditioner;

    localparam int DB = (1000 / 1000) * 4;
    localparam int LP = (1000 / 1000) * 20;
`ifdef KEY_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk;
    logic rst = 1'b1;
    logic key = 1'b1;
    logic sw  = 1'b0;
    logic start_p, clear_p, mode_clean, mode_chg;

    key_conditioner #(
        .CLK_HZ        (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (20)
    ) dut (
        .CLK_50MHz        (clk),
        .rst              (rst),
        .StartStopKey     (key),
        .ModeSw           (sw),
        .StartStopPulse   (start_p),
        .ClearPulse       (clear_p),
        .ModeSelClean     (mode_clean),
        .ModeChangedPulse (mode_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: inputs are seen two clocks late; a key level is
    // accepted after DB+1 disagreeing samples, a switch level after DB.
    // ------------------------------------------------------------------
    bit m_k1, m_k2, m_kacc, m_s1, m_s2, m_sacc, m_primed;
    bit ks, ss;
    int m_krun, m_srun, m_hold;
    bit e_start, e_clear, e_chg;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_k1 = 1'b1; m_k2 = 1'b1; m_kacc = 1'b1; m_krun = 0; m_hold = 0;
            m_s1 = 1'b0; m_s2 = 1'b0; m_sacc = 1'b0; m_srun = 0; m_primed = 1'b0;
            e_start = 1'b0; e_clear = 1'b0; e_chg = 1'b0;
        end else begin
            ks = m_k2; m_k2 = m_k1; m_k1 = key;
            ss = m_s2; m_s2 = m_s1; m_s1 = sw;
            e_start = 1'b0; e_clear = 1'b0; e_chg = 1'b0;
            // held time of an accepted press
            if (m_kacc == 1'b0 && m_hold < LP) begin
                m_hold++;
                if (m_hold == LP) e_clear = LP_EN;
            end
            if (ks != m_kacc) begin
                m_krun++;
                if (m_krun == DB + 1) begin
                    m_kacc  = ks;
                    m_krun  = 0;
                    m_hold  = 0;
                    e_start = (ks == 1'b0);
                end
            end else begin
                m_krun = 0;
            end
            if (ss != m_sacc) begin
                m_srun++;
                if (m_srun == DB) begin
                    m_sacc   = ss;
                    m_srun   = 0;
                    e_chg    = m_primed;
                    m_primed = 1'b1;
                end
            end else begin
                m_srun = 0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    int total = 0;
    int bad   = 0;
    int seg_cyc, seg_start, seg_clear, seg_chg;
    int first_start, first_clear, first_chg, first_hi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic seg_reset();
        seg_cyc = 0; seg_start = 0; seg_clear = 0; seg_chg = 0;
        first_start = -1; first_clear = -1; first_chg = -1; first_hi = -1;
    endtask

    // Drive inputs (just after a falling edge), then sample at the next one.
    task automatic step(input bit r, input bit k, input bit s);
        rst = r; key = k; sw = s;
        @(negedge clk);
        seg_cyc++;
        check("start", {31'd0, start_p},    {31'd0, e_start});
        check("clear", {31'd0, clear_p},    {31'd0, e_clear});
        check("mode",  {31'd0, mode_clean}, {31'd0, m_sacc});
        check("chg",   {31'd0, mode_chg},   {31'd0, e_chg});
        if (start_p === 1'b1) begin seg_start++; if (first_start < 0) first_start = seg_cyc; end
        if (clear_p === 1'b1) begin seg_clear++; if (first_clear < 0) first_clear = seg_cyc; end
        if (mode_chg === 1'b1) begin seg_chg++; if (first_chg < 0) first_chg = seg_cyc; end
        if (mode_clean === 1'b1 && first_hi < 0) first_hi = seg_cyc;
    endtask

    task automatic hold(input int n, input bit r, input bit k, input bit s);
        for (int i = 0; i < n; i++) step(r, k, s);
    endtask

    initial begin
        @(negedge clk);
        // reset state
        seg_reset();
        hold(3, 1'b1, 1'b1, 1'b0);
        check("rst_start", {31'd0, start_p},    32'd0);
        check("rst_clear", {31'd0, clear_p},    32'd0);
        check("rst_mode",  {31'd0, mode_clean}, 32'd0);
        check("rst_chg",   {31'd0, mode_chg},   32'd0);
        hold(4, 1'b0, 1'b1, 1'b0);

        // single press held 10 cycles
        seg_reset();
        hold(10, 1'b0, 1'b0, 1'b0);
        check("press_cnt", seg_start, 32'd1);
        check("press_lat", first_start, 32'd7);
        hold(10, 1'b0, 1'b1, 1'b0);
        check("press_once", seg_start, 32'd1);
        check("press_noclr", seg_clear, 32'd0);

        // bouncing key, then stable hold
        seg_reset();
        for (int i = 0; i < 3; i++) begin
            hold(2, 1'b0, 1'b0, 1'b0);
            hold(2, 1'b0, 1'b1, 1'b0);
        end
        check("bounce_quiet", seg_start, 32'd0);
        seg_reset();
        hold(12, 1'b0, 1'b0, 1'b0);
        check("bounce_cnt", seg_start, 32'd1);
        check("bounce_lat", first_start, 32'd7);
        hold(12, 1'b0, 1'b1, 1'b0);

        // long press
        seg_reset();
        hold(40, 1'b0, 1'b0, 1'b0);
        check("lp_start", seg_start, 32'd1);
        check("lp_cnt", seg_clear, LP_EN ? 32'd1 : 32'd0);
        check("lp_lat", first_clear, LP_EN ? 32'd27 : 32'hFFFF_FFFF);
        hold(12, 1'b0, 1'b1, 1'b0);

        // short glitches on both inputs
        seg_reset();
        hold(3, 1'b0, 1'b0, 1'b0);
        hold(8, 1'b0, 1'b1, 1'b0);
        hold(3, 1'b0, 1'b1, 1'b1);
        hold(8, 1'b0, 1'b1, 1'b0);
        check("glitch_key", seg_start, 32'd0);
        check("glitch_sw", seg_chg, 32'd0);
        check("glitch_lvl", {31'd0, mode_clean}, 32'd0);

        // switch high through reset release, then a stable 1 -> 0
        hold(3, 1'b1, 1'b1, 1'b1);
        seg_reset();
        hold(10, 1'b0, 1'b1, 1'b1);
        check("sw_init_lat", first_hi, 32'd6);
        check("sw_init_chg", seg_chg, 32'd0);
        seg_reset();
        hold(10, 1'b0, 1'b1, 1'b0);
        check("sw_fall_cnt", seg_chg, 32'd1);
        check("sw_fall_lat", first_chg, 32'd6);
        check("sw_fall_lvl", {31'd0, mode_clean}, 32'd0);

        // reset while pressed, key still held afterwards
        seg_reset();
        hold(10, 1'b0, 1'b0, 1'b0);
        check("rp_press", seg_start, 32'd1);
        seg_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("rp_rst_out", {28'd0, start_p, clear_p, mode_clean, mode_chg}, 32'd0);
        end
        seg_reset();
        hold(12, 1'b0, 1'b0, 1'b0);
        check("rp_cnt", seg_start, 32'd1);
        check("rp_lat", first_start, 32'd7);
        hold(10, 1'b0, 1'b1, 1'b0);

        // randomized run lengths on both inputs, checked every cycle
        for (int i = 0; i < 300; i++) begin
            bit rk, rs;
            int len;
            rk  = 1'($urandom_range(0, 1));
            rs  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 12));
            hold(len, 1'b0, rk, rs);
        end
        hold(30, 1'b0, 1'b0, 1'b1);
        hold(10, 1'b0, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
